// File: rtl/time_adjust_ctrl.sv
// Time-setting controller: shadows the running BCD time, lets the user step the
// minutes and hours fields, and strobes each edited value back into the clock counter.
module time_adjust_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 60,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [21:0] count,
    output logic        en,
    output logic [1:0]  en_Time,
    output logic        load,
    output logic [21:0] load_count
);

    typedef enum logic [1:0] {StIdle, StAdjMin, StAdjHr} state_e;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic [21:0]       shadow_q, shadow_d;
    logic [TO_W-1:0]   inact_q, inact_d;
    logic              load_q, load_d;
    logic              en_q, en_d;
    logic [1:0]        en_time_q, en_time_d;
    logic              step;

    // Illegal BCD in any field collapses to 00 on either direction.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [3:0] t, o;
        t = m[7:4];
        o = m[3:0];
        if (t > 4'd5 || o > 4'd9) return 8'h00;
        if (o == 4'd9) return (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] min_dec(input logic [7:0] m);
        logic [3:0] t, o;
        t = m[7:4];
        o = m[3:0];
        if (t > 4'd5 || o > 4'd9) return 8'h00;
        if (m == 8'h00) return 8'h59;
        if (o == 4'd0) return {t - 4'd1, 4'd9};
        return {t, o - 4'd1};
    endfunction

    function automatic logic hr_legal(input logic [5:0] h);
        return (h[3:0] <= 4'd9) &&
               ((h[5:4] < 2'd2) || (h[5:4] == 2'd2 && h[3:0] <= 4'd3));
    endfunction

    function automatic logic [5:0] hr_inc(input logic [5:0] h);
        if (!hr_legal(h)) return 6'h00;
        if (h == 6'h23) return 6'h00;
        if (h[3:0] == 4'd9) return {h[5:4] + 2'd1, 4'd0};
        return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] hr_dec(input logic [5:0] h);
        if (!hr_legal(h)) return 6'h00;
        if (h == 6'h00) return 6'h23;
        if (h[3:0] == 4'd0) return {h[5:4] - 2'd1, 4'd9};
        return {h[5:4], h[3:0] - 4'd1};
    endfunction

    assign step = btn_up ^ btn_down;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        inact_d  = inact_q;
        load_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                inact_d = '0;
                if (btn_mode) begin
                    shadow_d = {count[21:8], 8'h00};
                    state_d  = StAdjMin;
                end
            end
            StAdjMin, StAdjHr: begin
                // Timeout wins over any button arriving on the same cycle.
                if (inact_q == TimeoutVal) begin
                    state_d = StIdle;
                    inact_d = '0;
                end else if (btn_mode) begin
                    state_d = (state_q == StAdjMin) ? StAdjHr : StIdle;
                    inact_d = '0;
                end else if (step) begin
                    inact_d = '0;
                    load_d  = 1'b1;
                    if (state_q == StAdjMin) begin
                        shadow_d[15:8] = btn_up ? min_inc(shadow_q[15:8]) : min_dec(shadow_q[15:8]);
                    end else begin
                        shadow_d[21:16] = btn_up ? hr_inc(shadow_q[21:16]) : hr_dec(shadow_q[21:16]);
                    end
                end else begin
                    inact_d = inact_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs follow the next state so they are registered alongside it.
    always_comb begin
        en_d      = (state_d == StIdle);
        en_time_d = 2'b00;
        if (state_d == StAdjMin) en_time_d = 2'b01;
        if (state_d == StAdjHr)  en_time_d = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            inact_q   <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b1;
            en_time_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            inact_q   <= inact_d;
            load_q    <= load_d;
            en_q      <= en_d;
            en_time_q <= en_time_d;
        end
    end

    assign en         = en_q;
    assign en_Time    = en_time_q;
    assign load       = load_q;
    assign load_count = shadow_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Bench for time_adjust_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against an arithmetic model of the time fields.
module tb_time_adjust_ctrl;

    localparam int TO = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [21:0] count = '0;
    logic        en, load;
    logic [1:0]  en_Time;
    logic [21:0] load_count;

    int n_total = 0;
    int n_pass  = 0;

    time_adjust_ctrl #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .count      (count),
        .en         (en),
        .en_Time    (en_Time),
        .load       (load),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Field value as a plain number, or -1 if the BCD digits are not a legal value < lim.
    function automatic int field_val(input logic [3:0] t, input logic [3:0] o, input int lim);
        int v;
        if (o > 9) return -1;
        v = int'(t) * 10 + int'(o);
        return (v >= lim) ? -1 : v;
    endfunction

    function automatic logic [7:0] field_enc(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Reference model: state 0=idle, 1=minutes, 2=hours.
    int          m_state = 0;
    int          m_cnt   = 0;
    logic [21:0] m_sh    = '0;
    logic        m_load  = 1'b0;
    bit          m_valid = 1'b0;

    initial begin
        logic r, bm, bu, bd;
        logic [21:0] c;
        int v;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            r = rst; bm = btn_mode; bu = btn_up; bd = btn_down; c = count;
            m_load = 1'b0;
            if (r) begin
                m_state = 0; m_cnt = 0; m_sh = '0; m_valid = 1'b1;
            end else if (m_state == 0) begin
                m_cnt = 0;
                if (bm) begin m_sh = {c[21:8], 8'h00}; m_state = 1; end
            end else if (m_cnt == TO) begin
                m_state = 0; m_cnt = 0;
            end else if (bm) begin
                m_state = (m_state == 1) ? 2 : 0; m_cnt = 0;
            end else if (bu != bd) begin
                m_cnt = 0; m_load = 1'b1;
                if (m_state == 1) begin
                    v = field_val(m_sh[15:12], m_sh[11:8], 60);
                    v = (v < 0) ? 0 : (bu ? (v + 1) % 60 : (v + 59) % 60);
                    m_sh[15:8] = field_enc(v);
                end else begin
                    v = field_val({2'b00, m_sh[21:20]}, m_sh[19:16], 24);
                    v = (v < 0) ? 0 : (bu ? (v + 1) % 24 : (v + 23) % 24);
                    e = field_enc(v);
                    m_sh[21:16] = e[5:0];
                end
            end else begin
                m_cnt++;
            end
            #1;
            if (m_valid) begin
                chk("en", 32'(en), 32'(m_state == 0));
                chk("en_Time", 32'(en_Time), (m_state == 1) ? 32'd1 : (m_state == 2) ? 32'd2 : 32'd0);
                chk("load", 32'(load), 32'(m_load));
                chk("load_count", 32'(load_count), 32'(m_sh));
            end
        end
    end

    // Drive at a falling edge, then wait for the next falling edge.
    task automatic step(input logic r, input logic m, input logic u, input logic d);
        rst = r; btn_mode = m; btn_up = u; btn_down = d;
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic e_en, input logic [1:0] e_t,
                       input logic e_ld, input logic [21:0] e_lc);
        chk({name, ".en"}, 32'(en), 32'(e_en));
        chk({name, ".en_Time"}, 32'(en_Time), 32'(e_t));
        chk({name, ".load"}, 32'(load), 32'(e_ld));
        chk({name, ".load_count"}, 32'(load_count), 32'(e_lc));
    endtask

    initial begin
        int n;
        int act;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pin("reset", 1'b1, 2'b00, 1'b0, 22'h0);

        count = 22'h235941;
        step(0, 1, 0, 0);
        pin("enter_min", 1'b0, 2'b01, 1'b0, 22'h235900);
        step(0, 0, 1, 0);
        pin("min_wrap", 1'b0, 2'b01, 1'b1, 22'h230000);
        step(0, 0, 0, 0);
        pin("load_one_cycle", 1'b0, 2'b01, 1'b0, 22'h230000);
        step(0, 0, 0, 1);
        pin("min_borrow", 1'b0, 2'b01, 1'b1, 22'h235900);
        step(0, 0, 1, 1);
        pin("up_down_conflict", 1'b0, 2'b01, 1'b0, 22'h235900);
        step(0, 1, 0, 0);
        pin("enter_hr", 1'b0, 2'b10, 1'b0, 22'h235900);
        step(0, 0, 1, 0);
        pin("hr_wrap", 1'b0, 2'b10, 1'b1, 22'h005900);
        step(0, 0, 0, 1);
        pin("hr_borrow", 1'b0, 2'b10, 1'b1, 22'h235900);
        step(0, 1, 1, 0);
        pin("mode_priority", 1'b1, 2'b00, 1'b0, 22'h235900);

        // Illegal captured fields collapse to 00.
        count = 22'h2A7C33;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        pin("illegal_min", 1'b0, 2'b01, 1'b1, 22'h2A0000);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        pin("illegal_hr", 1'b0, 2'b10, 1'b1, 22'h000000);

        // Reset aborts mid-adjust with a load pending.
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        pin("rst_in_hr", 1'b1, 2'b00, 1'b0, 22'h0);

        // Timeout: TO+1 quiet edges after entry bring the block back to idle.
        count = 22'h125959;
        step(0, 1, 0, 0);
        n = 0;
        while (en !== 1'b1 && n < TO + 10) begin
            step(0, 0, 0, 0);
            n++;
        end
        act = n;
        chk("timeout_cycles", 32'(act), 32'(TO + 1));
        pin("timeout_state", 1'b1, 2'b00, 1'b0, 22'h125900);

        // Random traffic with alternating busy and quiet phases so timeouts occur.
        for (int blk = 0; blk < 40; blk++) begin
            int act_pct;
            act_pct = (blk % 3 == 2) ? 0 : 40;
            for (int i = 0; i < 90; i++) begin
                logic r, m, u, d;
                if ($urandom_range(99) < 50)
                    count = {field_enc($urandom_range(23)) & 8'h3F, field_enc($urandom_range(59)),
                             field_enc($urandom_range(59))} ;
                else
                    count = 22'($urandom);
                r = ($urandom_range(299) == 0);
                m = ($urandom_range(99) < (act_pct / 5));
                u = ($urandom_range(99) < act_pct);
                d = ($urandom_range(99) < act_pct);
                step(r, m, u, d);
            end
        end
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_adjust_ctrl.md
TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 60, idle clk cycles in an adjust state before automatic return to IDLE.
REQ-002 Parameter: TO_W, default 8, width of the inactivity counter; SHALL satisfy 2^TO_W > TIMEOUT_CYC.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 btn_mode  input  1  single-cycle pulse (debounced upstream); advances the adjust mode.
REQ-006 btn_up  input  1  single-cycle pulse; increments the selected field.
REQ-007 btn_down  input  1  single-cycle pulse; decrements the selected field.
REQ-008 count  input  22  current BCD time from the clock counter: [21:20] hr tens, [19:16] hr ones, [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
REQ-009 en  output  1  run enable to the clock counter; 1 = free-running time.
REQ-010 en_Time  output  2  field enable to the clock counter: 2'b01 = minutes, 2'b10 = hours, 2'b00 = none.
REQ-011 load  output  1  one-cycle load strobe to the clock counter.
REQ-012 load_count  output  22  BCD value to load, same field layout as count.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADJ_MIN and ADJ_HR.
REQ-014 In IDLE: en=1, en_Time=00, load=0; btn_up and btn_down are ignored.
REQ-015 On btn_mode in IDLE: shadow <= {count[21:8], 8'h00}; next state ADJ_MIN.
REQ-016 On btn_mode in ADJ_MIN: next state ADJ_HR.
REQ-017 On btn_mode in ADJ_HR: next state IDLE.
REQ-018 In ADJ_MIN: en=0, en_Time=01.
REQ-019 In ADJ_HR: en=0, en_Time=10.
REQ-020 All outputs SHALL be registered; en and en_Time change in the cycle after the edge that changes state.
REQ-021 In ADJ_MIN, btn_up SHALL increment the minutes field in BCD (00..59 -> 00, no carry into hours); btn_down SHALL decrement it (00 -> 59, no borrow).
REQ-022 In ADJ_HR, btn_up SHALL increment the hours field in BCD (00..23 -> 00); btn_down SHALL decrement it (00 -> 23).
REQ-023 Any field holding a non-legal BCD value (ones > 9, min tens > 5, hours > 23) SHALL become 00 on either up or down.
REQ-024 Load latency: a button pulse sampled at edge N updates shadow at edge N; load=1 for exactly the cycle after edge N, with load_count = updated shadow.
REQ-025 load_count SHALL hold the shadow value at all times outside reset; its seconds field SHALL be 8'h00.
REQ-026 btn_up and btn_down asserted in the same cycle SHALL be ignored: no change, no load.
REQ-027 btn_mode SHALL take priority over btn_up and btn_down in the same cycle; the up/down press is dropped.
REQ-028 The inactivity counter SHALL clear on entry to an adjust state and on any accepted button pulse, and SHALL increment on every other cycle spent in ADJ_MIN or ADJ_HR.
REQ-029 When the inactivity counter reaches TIMEOUT_CYC, the next state SHALL be IDLE, with no load issued.
REQ-030 Leaving an adjust state SHALL NOT generate a load; the last loaded value stands.
REQ-031 Back-to-back button pulses on consecutive cycles SHALL each produce their own update and their own one-cycle load.

Reset
REQ-032 While rst=1 at an edge: state=IDLE, en=1, en_Time=00, load=0, load_count=0, shadow=0, inactivity counter=0.
REQ-033 rst asserted mid-adjust SHALL abort at the next edge; no pending load is emitted after reset.

Verification
REQ-034 Reset check: assert rst for 2 cycles -> en=1, en_Time=00, load=0, load_count=22'h0.
REQ-035 Minute wrap: count=23:59:41, then btn_mode, then btn_up -> en=0, en_Time=01; load high 1 cycle with load_count=23:00:00 (hours unchanged).
REQ-036 Minute borrow: in ADJ_MIN with minutes=00, apply btn_down -> load_count minutes=59, hours unchanged.
REQ-037 Hour wrap: in ADJ_HR with hours=23, apply btn_up -> hours 00; then btn_down -> hours 23; exactly two one-cycle loads.
REQ-038 Timeout: enter ADJ_MIN and apply no buttons for TIMEOUT_CYC cycles -> state IDLE, en=1, en_Time=00, no load.
REQ-039 Conflicts: btn_up+btn_down together -> no load; btn_mode+btn_up together -> state advances only; rst during ADJ_HR -> IDLE and load=0 next cycle.
